misr_sig_analyzer: RTL and testbench

- Downstream BIST stage for the ripple-carry adder.
- Compacts the adder's response word {co, sum} into an (N+1)-bit multiple-input signature register (MISR) over a programmed number of patterns.
- At the end of the run it flags pass/fail against a golden signature.
- Sits between the adder outputs and the BIST controller/scan readout.

---
 rtl/misr_sig_analyzer.sv | 117 +++++++++++
 tb/tb_misr_sig_analyzer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misr_sig_analyzer.sv
// misr_sig_analyzer: BIST response compactor that sits behind the ripple-carry adder.
// The word {co, sum} is folded into an (N+1)-bit Galois MISR. The number of folded
// samples is fixed by pattern_count, which is captured on start. At the end of a run,
// done is raised and pass compares the frozen signature against golden.
//
// Optional build macro: MISR_MASK_EN
//   When it is defined, an in_mask port is added. Any response bit whose in_mask bit
//   is 1 is blocked, so X or unknown bits cannot enter the signature.
//   When it is undefined, the port is absent and no mask logic is built.
module misr_sig_analyzer #(
  parameter int         N     = 16,
  parameter int         CNT_W = 8,
  parameter logic [N:0] POLY  = 17'h00009,
  parameter logic [N:0] SEED  = 17'h00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pattern_count,
  input  logic [N:0]       golden,
  input  logic             in_valid,
  input  logic [N-1:0]     sum,
  input  logic             co,
`ifdef MISR_MASK_EN
  input  logic [N:0]       in_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N:0]       signature
);

  localparam int W = N + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_lat;
  logic [W-1:0]     d;
  logic [W-1:0]     sig_next;
  logic             last_sample;

  // Response word that is compacted; masked bits are forced to 0 before folding
`ifdef MISR_MASK_EN
  assign d = {co, sum} & ~in_mask;
`else
  assign d = {co, sum};
`endif

  // Galois MISR step: shift left, feed the MSB back through POLY, and fold in d
  always_comb begin
    sig_next = {signature[W-2:0], 1'b0} ^ (signature[W-1] ? POLY : '0) ^ d;
  end

  // The accepted sample that completes the programmed count
  assign last_sample = (cnt == cnt_lat - 1'b1);

  // Run control FSM with registered busy/done decodes, the MISR, and the sample counter
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled only on the clock edge (synchronous), and every state
    // register uses <= so all of them update together from pre-edge values.
    if (rst) begin
      state     <= IDLE;
      signature <= SEED;
      cnt       <= '0;
      cnt_lat   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A start in DONE restarts the analyzer exactly like a start in IDLE
          if (start) begin
            signature <= SEED;
            cnt       <= '0;
            cnt_lat   <= pattern_count;
            if (pattern_count != '0) begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          // start is ignored here; in_valid=0 stalls the run with no update
          if (in_valid) begin
            signature <= sig_next;
            cnt       <= cnt + 1'b1;
            if (last_sample) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // While done is high, pass follows golden with no register in the path
  assign pass = done & (signature == golden);

endmodule

// File: tb/tb_misr_sig_analyzer.sv
// tb_misr_sig_analyzer: bench for misr_sig_analyzer.
// Random and directed runs are issued. When a run is issued, its expected final
// signature and pass value are computed and pushed into a queue. A separate monitor
// process pops one entry each time done rises and compares it with the DUT outputs.
// Per-sample and per-state checks are made inline by the stimulus.
module tb_misr_sig_analyzer;

  localparam int          N     = 16;
  localparam int          CNT_W = 8;
  localparam logic [16:0] POLY  = 17'h00009;
  localparam logic [16:0] SEED  = 17'h00000;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] pattern_count;
  logic [N:0]       golden;
  logic             in_valid;
  logic [N-1:0]     sum;
  logic             co;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N:0]       signature;
`ifdef MISR_MASK_EN
  logic [N:0]       in_mask;
`endif

  misr_sig_analyzer #(
    .N    (N),
    .CNT_W(CNT_W),
    .POLY (POLY),
    .SEED (SEED)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pattern_count(pattern_count),
    .golden       (golden),
    .in_valid     (in_valid),
    .sum          (sum),
    .co           (co),
`ifdef MISR_MASK_EN
    .in_mask      (in_mask),
`endif
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] sig;
    logic        pass;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [16:0] stim_q[$];
  logic [16:0] mask_q[$];
  logic [16:0] last_exp;
  logic        done_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: multiply the signature polynomial by x modulo x^17+x^3+1,
  // then add the data word (addition over GF(2) is XOR)
  function automatic logic [16:0] misr_step(input logic [16:0] s, input logic [16:0] d);
    int unsigned v;
    v = 32'(s) * 2;
    if (v >= (32'd1 << 17)) v = (v - (32'd1 << 17)) ^ 32'(POLY);
    return v[16:0] ^ d;
  endfunction

  function automatic logic [16:0] model_run();
    logic [16:0] s = SEED;
    foreach (stim_q[i]) s = misr_step(s, stim_q[i] & ~mask_q[i]);
    return s;
  endfunction

  task automatic add_word(input logic [16:0] w, input logic [16:0] m);
    stim_q.push_back(w);
    mask_q.push_back(m);
  endtask

  // Scoreboard monitor: on each rising edge of done, compare against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done actual=done required=no_done at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_signature", 32'(signature), 32'(e.sig));
        check("sb_pass", 32'(pass), 32'(e.pass));
        check("sb_busy", 32'(busy), 32'd0);
      end
    end
    done_q <= done;
  end

  // Issue one run using the words in stim_q/mask_q, then clear both queues
  task automatic do_run(input logic [16:0] gold, input bit gold_is_exp,
                        input int stall_at, input int stall_len, input bit start_mid);
    int          cnt;
    logic [16:0] fin;
    logic [16:0] s;
    exp_t        e;
    cnt = stim_q.size();
    fin = model_run();
    @(negedge clk);
    #1;
    golden = gold_is_exp ? fin : gold;
    e.sig  = fin;
    e.pass = (golden == fin);
    exp_q.push_back(e);
    start         = 1'b1;
    pattern_count = CNT_W'(cnt);
    @(posedge clk);
    #1;
    start = 1'b0;
    s = SEED;
    check("start_sig_seed", 32'(signature), 32'(SEED));
    if (cnt == 0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
    end else begin
      check("start_busy", 32'(busy), 32'd1);
      check("start_done", 32'(done), 32'd0);
      check("start_pass", 32'(pass), 32'd0);
    end
    for (int i = 0; i < cnt; i++) begin
      if (i == stall_at) begin
        repeat (stall_len) begin
          in_valid = 1'b0;
          {co, sum} = 17'($urandom);
          @(posedge clk);
          #1;
          check("stall_sig", 32'(signature), 32'(s));
          check("stall_busy", 32'(busy), 32'd1);
        end
      end
      in_valid  = 1'b1;
      {co, sum} = stim_q[i];
`ifdef MISR_MASK_EN
      in_mask = mask_q[i];
`endif
      if (start_mid && i == 1) begin
        start         = 1'b1;
        pattern_count = CNT_W'($urandom_range(1, 255));
      end
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = 1'b0;
      s = misr_step(s, stim_q[i] & ~mask_q[i]);
      check("sample_sig", 32'(signature), 32'(s));
      if (i < cnt - 1) begin
        check("run_busy", 32'(busy), 32'd1);
        check("run_done", 32'(done), 32'd0);
      end else begin
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_pass", 32'(pass), 32'(golden == s));
      end
    end
    last_exp = fin;
    stim_q.delete();
    mask_q.delete();
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    pattern_count = '0;
    golden        = '0;
    in_valid      = 1'b0;
    sum           = '0;
    co            = 1'b0;
`ifdef MISR_MASK_EN
    in_mask       = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_sig", 32'(signature), 32'(SEED));
    rst = 1'b0;

    // A zero pattern count goes straight to DONE with the signature still at SEED
    do_run(17'h00000, 1'b0, -1, 0, 1'b0);
    check("zero_sig", 32'(signature), 32'h00000);

    // Two-pattern run, restarted from DONE
    add_word(17'h0FFFF, 17'h0);
    add_word(17'h10000, 17'h0);
    do_run(17'h0FFFE, 1'b0, -1, 0, 1'b0);
    check("tp_final", 32'(signature), 32'h0FFFE);
    check("tp_pass", 32'(pass), 32'd1);

    // Feedback path, with a three-cycle stall before the second sample
    add_word(17'h10000, 17'h0);
    add_word(17'h00000, 17'h0);
    do_run(17'h00008, 1'b0, 1, 3, 1'b0);
    check("fb_final", 32'(signature), 32'h00009);
    check("fb_pass", 32'(pass), 32'd0);

    // In DONE, golden is followed combinationally and in_valid is ignored
    #1 golden = last_exp;
    #1 check("gold_follow_hi", 32'(pass), 32'd1);
    golden = last_exp ^ 17'h1;
    #1 check("gold_follow_lo", 32'(pass), 32'd0);
    repeat (3) begin
      in_valid = 1'b1;
      {co, sum} = 17'($urandom);
      @(posedge clk);
      #1;
      check("done_hold_sig", 32'(signature), 32'(last_exp));
      check("done_hold", 32'(done), 32'd1);
    end
    in_valid = 1'b0;

    // Reset mid-run after 1 of 4 samples; in IDLE, in_valid is then ignored
    @(negedge clk);
    #1;
    start = 1'b1;
    pattern_count = 8'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b1;
    {co, sum} = 17'h1ABCD;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_sig", 32'(signature), 32'(SEED));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("idle_hold_sig", 32'(signature), 32'(SEED));
    for (int i = 0; i < 4; i++) add_word(17'($urandom), 17'h0);
    do_run(17'h0, 1'b1, -1, 0, 1'b0);

    // A start pulse during RUN is ignored
    for (int i = 0; i < 5; i++) add_word(17'($urandom), 17'h0);
    do_run(17'h0, 1'b1, 2, 2, 1'b1);

    // Longest run allowed by the counter width
    for (int i = 0; i < 255; i++) add_word(17'($urandom), 17'h0);
    do_run(17'h0, 1'b1, 100, 1, 1'b0);

`ifdef MISR_MASK_EN
    // When every bit is masked, the signature matches the SEED-only evolution
    for (int i = 0; i < 6; i++) add_word(17'($urandom), 17'h1FFFF);
    do_run(17'h00000, 1'b0, -1, 0, 1'b0);
    check("mask_all_sig", 32'(signature), 32'h00000);
`endif

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
`ifdef MISR_MASK_EN
        add_word(17'($urandom), 17'($urandom));
`else
        add_word(17'($urandom), 17'h0);
`endif
      end
      do_run(17'($urandom), ($urandom_range(0, 1) == 1), $urandom_range(0, n), $urandom_range(1, 3),
             ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
